key_debouncer: RTL and testbench



---
 rtl/tick_gen.sv | 32 +++
 rtl/key_debouncer.sv | 89 ++++++++
 tb/tb_key_debouncer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/tick_gen.sv
// Free-running prescaler that produces a one-cycle strobe every DIV clocks.
// Latency: first strobe DIV-1 cycles after reset is released, then every DIV cycles.
// Backpressure: none; the strobe is free-running and cannot be stalled.
module tick_gen #(
    parameter int DIV = 256
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    // A counter of at least one bit keeps the declaration legal for the smallest divider.
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] pcnt;

    // Count 0..DIV-1 and wrap; reset parks the phase at 0 so the strobe is low while held.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= '0;
        end else if (pcnt == LAST) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    // The strobe is decoded straight from the phase so every consumer sees the same cycle.
    assign tick = (pcnt == LAST);

endmodule

// File: rtl/key_debouncer.sv
// Multi-channel key debouncer: sync, sample on a shared tick, accept after STABLE_CNT agreeing samples.
// Latency: 2 + STABLE_CNT*TICK_DIV - (TICK_DIV-1) .. 2 + STABLE_CNT*TICK_DIV cycles from keyin to keyout.
// Backpressure: none; pulses are single-cycle and must be consumed in the cycle they appear.
//
// `release` is a reserved word in SystemVerilog (force/release), so the 1->0 pulse
// output is named release_pulse; press is kept plain for symmetry with the board signal names.
module key_debouncer #(
    parameter int WIDTH      = 5,
    parameter int TICK_DIV   = 256,
    parameter int STABLE_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] keyin,
    output logic [WIDTH-1:0] keyout,
    output logic [WIDTH-1:0] press,
    output logic [WIDTH-1:0] release_pulse,
    output logic             tick
);

    // Counter must hold STABLE_CNT-1 as its terminal value; size for STABLE_CNT+1 states.
    localparam int CW = (STABLE_CNT > 0) ? $clog2(STABLE_CNT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

    logic sample_tick;

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (sample_tick)
    );

    assign tick = sample_tick;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan

        logic          meta;
        logic          sync;
        logic [CW-1:0] cnt;
        logic          key_q;
        logic          press_q;
        logic          rel_q;

        // Two-flop synchroniser: the raw button is asynchronous to clk.
        always_ff @(posedge clk) begin
            if (rst) begin
                meta <= 1'b0;
                sync <= 1'b0;
            end else begin
                meta <= keyin[i];
                sync <= meta;
            end
        end

        // Stability counter and debounced level; only tick edges move them, and any
        // sample agreeing with the current level throws away the partial count.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt     <= '0;
                key_q   <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                if (sample_tick) begin
                    if (sync == key_q) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        key_q   <= sync;
                        cnt     <= '0;
                        press_q <= sync;
                        rel_q   <= ~sync;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end

        assign keyout[i]        = key_q;
        assign press[i]         = press_q;
        assign release_pulse[i] = rel_q;

    end

endmodule

// File: tb/tb_key_debouncer.sv
// Randomised scoreboard bench for key_debouncer against a sample-history reference model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_key_debouncer;

    localparam int W = 5;
    localparam int D = 4;
    localparam int K = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] keyin = '0;
    logic [W-1:0] keyout;
    logic [W-1:0] press;
    logic [W-1:0] release_pulse;
    logic         tick;

    always #5 clk = ~clk;

    key_debouncer #(
        .WIDTH      (W),
        .TICK_DIV   (D),
        .STABLE_CNT (K)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .keyin         (keyin),
        .keyout        (keyout),
        .press         (press),
        .release_pulse (release_pulse),
        .tick          (tick)
    );

    typedef struct packed {
        logic [W-1:0] ko;
        logic [W-1:0] pr;
        logic [W-1:0] rl;
        logic         tk;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: cycle index since reset, raw input history, and per
    // channel the most recent K tick samples.
    int           cyc;
    logic [W-1:0] kin[$];
    logic [W-1:0] m_out;
    logic [W-1:0] m_pr;
    logic [W-1:0] m_rl;
    bit           hist[W][$];
    bit           have_prev = 0;
    bit           prev_rst  = 0;
    bit           model_ok  = 0;

    task automatic model_reset();
        cyc   = 0;
        kin.delete();
        m_out = '0;
        m_pr  = '0;
        m_rl  = '0;
        for (int ch = 0; ch < W; ch++) hist[ch].delete();
        model_ok = 1;
    endtask

    // One clock cycle: advance the model across the edge just passed, drive the
    // new inputs, and queue what the DUT must show during this cycle.
    task automatic step(input logic r, input logic [W-1:0] k);
        logic [W-1:0] s;
        bit           all_diff;
        exp_t         e;
        @(posedge clk);
        #1;
        if (have_prev) begin
            m_pr = '0;
            m_rl = '0;
            if (prev_rst) begin
                model_reset();
            end else if (model_ok) begin
                if (cyc % D == D - 1) begin
                    s = (cyc >= 2) ? kin[cyc-2] : '0;
                    for (int ch = 0; ch < W; ch++) begin
                        hist[ch].push_back(s[ch]);
                        if (hist[ch].size() > K) void'(hist[ch].pop_front());
                        all_diff = (hist[ch].size() == K);
                        for (int j = 0; j < hist[ch].size(); j++)
                            if (hist[ch][j] == m_out[ch]) all_diff = 0;
                        if (all_diff) begin
                            m_out[ch] = ~m_out[ch];
                            if (m_out[ch]) m_pr[ch] = 1'b1;
                            else           m_rl[ch] = 1'b1;
                        end
                    end
                end
                cyc++;
            end
        end
        rst   = r;
        keyin = k;
        if (model_ok) begin
            kin.push_back(k);
            e.ko = m_out;
            e.pr = m_pr;
            e.rl = m_rl;
            e.tk = (cyc % D == D - 1);
            sb.push_back(e);
        end
        prev_rst  = r;
        have_prev = 1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, req);
        end
    endtask

    // Monitor: every cycle the DUT presents outputs; compare them mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("keyout", keyout, e.ko);
                chk("press", press, e.pr);
                chk("release", release_pulse, e.rl);
                chk("tick", {{(W-1){1'b0}}, tick}, {{(W-1){1'b0}}, e.tk});
            end
        end
    end

    initial begin
        logic [W-1:0] target;
        logic [W-1:0] kk;

        // Reset, then clean press on ch0 plus a 6-cycle glitch on ch1, release at cycle 20.
        repeat (3) step(1'b1, '0);
        for (int c = 0; c < 42; c++) begin
            if (c < 6)       kk = 5'b00011;
            else if (c < 20) kk = 5'b00001;
            else             kk = 5'b00000;
            step(1'b0, kk);
        end

        // Several channels together.
        step(1'b1, '0);
        for (int c = 0; c < 20; c++) step(1'b0, 5'b10110);
        for (int c = 0; c < 20; c++) step(1'b0, 5'b00000);

        // Reset in the middle of a debounce, then a full press after the restart.
        step(1'b1, '0);
        for (int c = 0; c < 9; c++) step(1'b0, 5'b00001);
        step(1'b1, 5'b00001);
        for (int c = 0; c < 20; c++) step(1'b0, 5'b00001);

        // Random bouncy keys with occasional resets.
        target = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int ch = 0; ch < W; ch++)
                if ($urandom_range(0, 39) == 0) target[ch] = ~target[ch];
            kk = target;
            for (int ch = 0; ch < W; ch++)
                if ($urandom_range(0, 99) < 8) kk[ch] = ~kk[ch];
            step(($urandom_range(0, 399) == 0), kk);
        end

        repeat (4) step(1'b0, target);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
